radix2_otfc: RTL
================

Name: radix2_otfc

Overview:
- Radix-2 on-the-fly converter (OTFC). Sits directly downstream of the radix-2 selection function in the online multiplier datapath.
- Consumes the signed output digit p_j ∈ {-1,0,+1}, one per cycle, most significant digit first.
- Builds the two's-complement result incrementally using the Q/QM register pair, so no carry-propagate adder is needed at the end.
- Presents the full conversion after no_of_digits digits, with a one-cycle valid pulse.

Parameters:
- no_of_digits, 8: number of digits per conversion (N).
- radix_bits, 2: width of one signed digit.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a new conversion; clears Q/QM.
- digit_valid  input  1  p_j is valid this cycle.
- p_j  input  radix_bits  signed digit: 2'b01=+1, 2'b00=0, 2'b11=-1.
- busy  output  1  high while a conversion is in progress.
- result  output  no_of_digits+1  two's-complement fraction: sign bit plus N fraction bits, LSB weight 2^-N.
- result_valid  output  1  one-cycle pulse when result is final.
- digit_err  output  1  present only with OTFC_ERR_EN.

Behaviour:
- Reset is synchronous and active-high: one clk, reset is synchronous active-high.
- Reset values:
  - state=IDLE, busy=0, result=0, result_valid=0, digit_err=0.
  - Q=0, QM=all ones, digit count=0.
- FSM states: IDLE, CONV, DONE.
  - IDLE→CONV on start. Q←0, QM←all ones (value -1), count←0.
  - CONV: each cycle with digit_valid=1, apply the update rule and increment count. When count reaches N-1 and a digit is accepted, go to DONE.
  - DONE: result←Q after the final update; result_valid=1 for exactly this one cycle. Unconditionally return to IDLE next cycle.
- Update rule. Registers are N+1 bits wide, shift left by 1, discard the MSB:
  - p=+1: Q←{Q,1}, QM←{Q,0}
  - p=0: Q←{Q,0}, QM←{QM,1}
  - p=-1: Q←{QM,1}, QM←{QM,0}
- Invariant: QM = Q - 2^-j after every accepted digit.
- Result value = Σ p_j·2^-j, range [-(1-2^-N), 1-2^-N]. Overflow is not possible.
- busy=1 in CONV and DONE, 0 in IDLE.
- digit_valid=0 in CONV: hold state and count; bubbles are allowed between digits.
- digit_valid in IDLE or DONE: ignored.
- start in any state (including CONV/DONE): restart. Reinitialise and enter CONV; any pending result_valid is suppressed.
- start and digit_valid in the same cycle: start wins; the digit is discarded.
- result holds its last value until the next DONE. It is not cleared by start.
- Code 2'b10 (illegal): converted as digit 0.
- reset in mid-conversion: return to reset values on the next edge; the partial result is lost.
- Latency: result_valid is asserted on the cycle after the N-th accepted digit.

Optional Feature:
- Macro: OTFC_ERR_EN.
- Defined:
  - digit_err port exists.
  - Set on any accepted digit with code 2'b10; sticky until start or reset.
  - The digit is still converted as 0.
  - result_valid still pulses normally.
- Undefined: no digit_err port and no error logic; 2'b10 is silently converted as 0.

Test Plan:
- Reset, then start; digits +1,-1,0,0,0,0,0,0 on 8 consecutive cycles → result=9'h040 (0.25), result_valid high for exactly 1 cycle, busy then low.
- Start; 8 digits of -1 → result=9'h101 (-255/256). Start; 8 digits of +1 → result=9'h0FF.
- Start; digits 0×7 then -1, with digit_valid bubbles inserted between digits 2/3 and 5/6 → result=9'h1FF (-1/256); result_valid occurs 1 cycle after the 8th accepted digit.
- Start; 4 digits of +1, then start again together with digit_valid (p=+1); then 8 digits of 0 → no pulse after the first 4 digits, restart digit discarded, result=9'h000.
- Reset asserted after 5 digits → busy=0, result_valid never pulses; subsequent full conversion of +1,0×7 → 9'h080.
- OTFC_ERR_EN: digit 2'b10 as 3rd digit of +1,+1,err,0×5 → digit_err=1 from the next cycle and held; result=9'h0C0; next start clears digit_err.

Source files
------------

// File: rtl/radix2_otfc.sv
// Radix-2 on-the-fly converter: turns MSB-first signed digits {-1,0,+1} into a
// two's-complement fraction via the Q/QM register pair. Optional OTFC_ERR_EN adds digit_err.
module radix2_otfc #(
    parameter int no_of_digits = 8,
    parameter int radix_bits   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           digit_valid,
    input  logic signed [radix_bits-1:0]   p_j,
    output logic                           busy,
    output logic        [no_of_digits:0]   result,
    output logic                           result_valid
`ifdef OTFC_ERR_EN
    ,
    output logic                           digit_err
`endif
);

    localparam int W     = no_of_digits + 1;
    localparam int CNT_W = $clog2(no_of_digits + 1);

    localparam logic signed [radix_bits-1:0] P_ZERO = '0;
    localparam logic signed [radix_bits-1:0] P_POS  = radix_bits'(1);
    localparam logic signed [radix_bits-1:0] P_NEG  = '1;

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t           state, state_nxt;
    logic [W-1:0]     q, qm, q_step, qm_step;
    logic [CNT_W-1:0] count;
    logic             accept, last;

    // One conversion step; the shift drops the MSB, so QM stays exactly Q - 2^-j.
    // Any code other than +1/-1 (including the illegal one) acts as digit 0.
    function automatic logic [2*W-1:0] otfc_step(input logic [W-1:0] q_in,
                                                 input logic [W-1:0] qm_in,
                                                 input logic signed [radix_bits-1:0] d);
        logic [2*W-1:0] nxt;
        if (d == P_POS)
            nxt = {q_in[W-2:0], 1'b1, q_in[W-2:0], 1'b0};
        else if (d == P_NEG)
            nxt = {qm_in[W-2:0], 1'b1, qm_in[W-2:0], 1'b0};
        else
            nxt = {q_in[W-2:0], 1'b0, qm_in[W-2:0], 1'b1};
        return nxt;
    endfunction

    assign {q_step, qm_step} = otfc_step(q, qm, p_j);

    // start always wins, so a digit presented alongside it is never accepted.
    assign accept = (state == CONV) && digit_valid && !start;
    assign last   = accept && (count == CNT_W'(no_of_digits - 1));

    always_comb begin
        state_nxt    = state;
        busy         = (state != IDLE);
        result_valid = (state == DONE);
        case (state)
            IDLE:    if (start) state_nxt = CONV;
            CONV:    if (start) state_nxt = CONV;
                     else if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? CONV : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            q      <= '0;
            qm     <= '1;
            count  <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                q     <= '0;
                qm    <= '1;
                count <= '0;
            end else if (accept) begin
                q     <= q_step;
                qm    <= qm_step;
                count <= count + 1'b1;
                if (last)
                    result <= q_step;
            end
        end
    end

`ifdef OTFC_ERR_EN
    // Sticky flag for the reserved code; cleared only by start or reset.
    always_ff @(posedge clk) begin
        if (reset || start)
            digit_err <= 1'b0;
        else if (accept && (p_j != P_ZERO) && (p_j != P_POS) && (p_j != P_NEG))
            digit_err <= 1'b1;
    end
`endif

endmodule
